// File: rtl/xor_arbiter.sv
// Two-requester arbiter feeding a single XOR unit: round-robin grant in IDLE,
// one cycle of execution, then the result is held until the consumer acknowledges.
module xor_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_id,
   input  logic             res_ack,
   output logic             busy,
   output logic [7:0]       op_count
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             ptr;
   logic             grant_any;
   logic             grant_id;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grant only in IDLE and never while rst is high, so ready is 0 during reset.
   always_comb begin
      state_next = state;
      grant_any  = 1'b0;
      grant_id   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (!rst) begin
               if (req0_valid && req1_valid) begin
                  grant_any = 1'b1;
                  grant_id  = ptr;
               end else if (req0_valid) begin
                  grant_any = 1'b1;
                  grant_id  = 1'b0;
               end else if (req1_valid) begin
                  grant_any = 1'b1;
                  grant_id  = 1'b1;
               end
            end
            req0_ready = grant_any && !grant_id;
            req1_ready = grant_any && grant_id;
            if (grant_any) begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            state_next = DONE;
         end
         DONE: begin
            if (res_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign res_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_id    <= 1'b0;
         res_data <= '0;
         res_id   <= 1'b0;
         op_count <= '0;
      end else begin
         if (state == IDLE && grant_any) begin
            op_a  <= grant_id ? req1_a : req0_a;
            op_b  <= grant_id ? req1_b : req0_b;
            op_id <= grant_id;
            ptr   <= ~grant_id;
         end
         if (state == EXEC) begin
            res_data <= op_a ^ op_b;
            res_id   <= op_id;
         end
         if (state == DONE && res_ack) begin
            op_count <= op_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_xor_arbiter.sv
// Directed self-checking bench for xor_arbiter: single op, contention, back-pressure,
// fairness, reset mid-operation and op_count wrap.
module tb_xor_arbiter;

   logic       clk;
   logic       rst;
   logic       req0_valid;
   logic [7:0] req0_a;
   logic [7:0] req0_b;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_a;
   logic [7:0] req1_b;
   logic       req1_ready;
   logic       res_valid;
   logic [7:0] res_data;
   logic       res_id;
   logic       res_ack;
   logic       busy;
   logic [7:0] op_count;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [7:0]  exp_count = 8'd0;

   xor_arbiter #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_id     (res_id),
      .res_ack    (res_ack),
      .busy       (busy),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered and left 1 time unit after a rising edge.
   task automatic do_reset();
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ack    = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_count = 8'd0;
   endtask

   // Waits for a grant, checks the whole pipeline timing of one operation, acks it.
   task automatic run_op(input logic exp_id, input logic [7:0] exp_data, input bit drop);
      int unsigned n;
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 8) begin
         @(posedge clk);
         #2;
         n++;
      end
      check_eq("grant", {req0_ready, req1_ready}, exp_id ? 32'd1 : 32'd2);
      @(posedge clk);
      #1;
      if (drop) begin
         if (exp_id) req1_valid = 1'b0;
         else        req0_valid = 1'b0;
      end
      #1;
      check_eq("exec_res_valid", res_valid, 1'b0);
      check_eq("exec_ready", {req0_ready, req1_ready}, 2'b00);
      check_eq("exec_busy", busy, 1'b1);
      @(posedge clk);
      #2;
      check_eq("done_res_valid", res_valid, 1'b1);
      check_eq("done_res_data", res_data, exp_data);
      check_eq("done_res_id", res_id, exp_id);
      res_ack = 1'b1;
      @(posedge clk);
      #1 res_ack = 1'b0;
      exp_count = exp_count + 8'd1;
      check_eq("after_ack_busy", busy, 1'b0);
      check_eq("op_count", op_count, exp_count);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_a = 8'h00; req0_b = 8'h00;
      req1_a = 8'h00; req1_b = 8'h00;
      res_ack    = 1'b0;
      @(posedge clk);
      #2;
      check_eq("rst_ready0", req0_ready, 1'b0);
      check_eq("rst_ready1", req1_ready, 1'b0);
      check_eq("rst_res_valid", res_valid, 1'b0);
      check_eq("rst_res_data", res_data, 8'h00);
      check_eq("rst_res_id", res_id, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_op_count", op_count, 8'h00);
      do_reset();

      // Ack while idle must not count
      res_ack = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 res_ack = 1'b0;
      check_eq("idle_ack_count", op_count, 8'h00);
      check_eq("idle_ack_busy", busy, 1'b0);

      req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h0F;
      run_op(1'b0, 8'hAA, 1'b1);

      do_reset();
      req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h00;
      req1_valid = 1'b1; req1_a = 8'h3C; req1_b = 8'h3C;
      run_op(1'b0, 8'hFF, 1'b1);
      run_op(1'b1, 8'h00, 1'b1);

      // Back-pressure; req1 raises valid while busy, then withdraws before a grant
      req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
      #1 check_eq("bp_grant0", req0_ready, 1'b1);
      @(posedge clk);
      #1 req0_valid = 1'b0; req1_valid = 1'b1;
      #1 check_eq("bp_ready1_exec", req1_ready, 1'b0);
      @(posedge clk);
      #2;
      check_eq("bp_res_valid", res_valid, 1'b1);
      check_eq("bp_res_data", res_data, 8'h26);
      check_eq("bp_res_id", res_id, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2;
         check_eq("bp_hold_valid", res_valid, 1'b1);
         check_eq("bp_hold_data", res_data, 8'h26);
         check_eq("bp_hold_id", res_id, 1'b0);
         check_eq("bp_hold_ready", {req0_ready, req1_ready}, 2'b00);
         check_eq("bp_hold_busy", busy, 1'b1);
      end
      req1_valid = 1'b0;
      res_ack = 1'b1;
      @(posedge clk);
      #1 res_ack = 1'b0;
      exp_count = exp_count + 8'd1;
      check_eq("bp_idle", busy, 1'b0);
      check_eq("bp_op_count", op_count, exp_count);
      @(posedge clk);
      #2 check_eq("withdrawn_no_grant", busy, 1'b0);

      do_reset();
      req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h0F;
      req1_valid = 1'b1; req1_a = 8'hC3; req1_b = 8'h81;
      for (int i = 0; i < 8; i++) begin
         run_op(i[0], i[0] ? 8'h42 : 8'h5A, 1'b0);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check_eq("fair_op_count", op_count, 8'd8);

      // Reset pulsed while the operation sits in EXEC
      req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
      #1 check_eq("mid_grant", req0_ready, 1'b1);
      @(posedge clk);
      #1 req0_valid = 1'b0; rst = 1'b1;
      #1 check_eq("mid_rst_busy", busy, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_count = 8'd0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check_eq("mid_no_result", res_valid, 1'b0);
      check_eq("mid_op_count", op_count, 8'd0);
      #3;
      req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h0F;
      run_op(1'b1, 8'hFF, 1'b1);

      do_reset();
      for (int i = 0; i < 256; i++) begin
         req0_valid = 1'b1; req0_a = i[7:0]; req0_b = 8'h5A;
         run_op(1'b0, i[7:0] ^ 8'h5A, 1'b1);
      end
      check_eq("wrap_op_count", op_count, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  meaning the reset; asynchronous, active-high.
REQ-004 The block SHALL have port req0_valid  input  1  meaning requester 0 holds an operand pair.
REQ-005 The block SHALL have port req0_a  input  WIDTH  meaning requester 0 operand A.
REQ-006 The block SHALL have port req0_b  input  WIDTH  meaning requester 0 operand B.
REQ-007 The block SHALL have port req0_ready  output  1  meaning requester 0 operands accepted this cycle.
REQ-008 The block SHALL have ports req1_valid, req1_a, req1_b and req1_ready, identical to the requester 0 ports, for requester 1.
REQ-009 The block SHALL have port res_valid  output  1  meaning res_data and res_id are valid.
REQ-010 The block SHALL have port res_data  output  WIDTH  meaning the registered result A^B.
REQ-011 The block SHALL have port res_id  output  1  meaning the index of the requester that owns res_data.
REQ-012 The block SHALL have port res_ack  input  1  meaning the consumer takes the result.
REQ-013 The block SHALL have port busy  output  1  meaning the state is not IDLE.
REQ-014 The block SHALL have port op_count  output  8  meaning completed operations, wrapping 255->0.

Function
REQ-015 The block SHALL implement the states IDLE, EXEC and DONE.
REQ-016 In IDLE, when one or more reqN_valid are high, the block SHALL grant exactly one requester and drive its reqN_ready high combinationally in that cycle; a transfer occurs when reqN_valid and reqN_ready are both high.
REQ-017 When both requesters are valid, the block SHALL grant the requester indicated by the priority pointer; after any grant, the pointer SHALL point to the other requester.
REQ-018 When only one requester is valid, the block SHALL grant it regardless of the pointer.
REQ-019 On a transfer, the block SHALL latch the operands and the granted index, and the state SHALL move to EXEC.
REQ-020 In EXEC, the block SHALL compute the bitwise XOR of the latched operands, register it into res_data, load res_id, and move to DONE.
REQ-021 In DONE, res_valid SHALL be 1, and res_data and res_id SHALL remain stable until res_ack is high.
REQ-022 With res_ack high in DONE, the block SHALL move to IDLE and increment op_count by 1 (mod 256).
REQ-023 res_ack SHALL be ignored outside DONE.
REQ-024 Latency: for a transfer in cycle T, res_valid SHALL rise in cycle T+2; the minimum issue interval SHALL be 3 cycles.
REQ-025 In EXEC and DONE, both reqN_ready outputs SHALL be 0; requesters hold their requests and are not dropped.
REQ-026 The block SHALL never assert both reqN_ready outputs in the same cycle.
REQ-027 The block SHALL never assert reqN_ready while reqN_valid is low.
REQ-028 A requester that deasserts valid before it is granted SHALL lose nothing; no state change SHALL occur.

Reset
REQ-029 While rst is high, the block SHALL hold state IDLE, priority pointer 0, res_valid 0, res_data 0, res_id 0, op_count 0, busy 0, and both reqN_ready 0.
REQ-030 An assertion of rst in EXEC or DONE SHALL discard the in-flight operation immediately, with no result delivered and op_count not incremented.
REQ-031 After rst is released, the first grant SHALL follow REQ-017/018 with the pointer at 0.

Verification
REQ-032 Single request: req0 sends a=8'hA5, b=8'h0F in cycle T -> req0_ready=1 at T; at T+2 res_valid=1, res_data=8'hAA, res_id=0; ack -> op_count=1.
REQ-033 Contention: both valid after reset (req0 a=FF b=00, req1 a=3C b=3C) -> req0 is served first (res_data=FF, id 0), then req1 (res_data=00, id 1); no cycle has both ready high.
REQ-034 Back-pressure: res_ack is held low for 10 cycles -> res_valid, res_data and res_id are stable, both ready outputs are 0, busy=1; ack -> IDLE next cycle.
REQ-035 Fairness: both requesters are continuously valid for 8 operations -> grants alternate 0,1,0,1,... and op_count=8.
REQ-036 Reset mid-operation: rst is pulsed in EXEC -> res_valid stays 0 and op_count=0; the request that follows completes normally.
REQ-037 Wrap: 256 completed operations -> op_count returns to 0.
